// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the 4-master system bus arbiter: master count,
// owner index type, fixed owner codes and the active-low enable levels used
// for request and grant comparisons.
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH      = 4;
    localparam int BUS_MASTER_INDEX_W = 2;

    typedef logic [BUS_MASTER_INDEX_W-1:0] BusOwnerBus;

    localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'd0;
    localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'd1;
    localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'd2;
    localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'd3;

    // Request and grant lines are active-low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker. Scans owner+1, owner+2, owner+3 (mod 4)
// and returns the first active requester. The current owner is never picked;
// valid is low when nobody else is requesting.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  BusOwnerBus               owner,
    input  logic [BUS_MASTER_CH-1:0] req,
    output BusOwnerBus               next_owner,
    output logic                     valid
);

    BusOwnerBus cand;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        next_owner = owner;
        valid      = 1'b0;
        cand       = owner;
        for (int i = BUS_MASTER_CH - 1; i >= 1; i--) begin
            cand = owner + BUS_MASTER_INDEX_W'(i);
            if (req[cand]) begin
                next_owner = cand;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 4-master bus. Active-low requests in,
// exactly one registered active-low grant out; the grant parks on the last
// owner when the bus is idle.
// Optional feature: define BUS_ARB_TIMEOUT_EN to build the tenure counter
// that forces rotation after TIMEOUT_CYCLES while another master waits.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMO_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       tmo_evt
);

    if ((2 ** TMO_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("bus_arbiter: TMO_W too narrow for TIMEOUT_CYCLES");
    end

    logic [BUS_MASTER_CH-1:0] req;
    BusOwnerBus               owner_q;
    logic [BUS_MASTER_CH-1:0] grnt_n_q;
    logic [BUS_MASTER_CH-1:0] grnt_n_next;
    BusOwnerBus               pick_idx;
    logic                     pick_valid;
    logic                     owner_req;
    logic                     rotate;

    assign req = {m3_req_ == ENABLE_, m2_req_ == ENABLE_,
                  m1_req_ == ENABLE_, m0_req_ == ENABLE_};

    assign owner_req = req[owner_q];

    // One picker serves both the voluntary release and the forced rotation.
    bus_arb_rr_pick u_pick (
        .owner      (owner_q),
        .req        (req),
        .next_owner (pick_idx),
        .valid      (pick_valid)
    );

    // Grant pattern for the picked master, built ahead of the register.
    always_comb begin
        grnt_n_next = {BUS_MASTER_CH{DISABLE_}};
        grnt_n_next[pick_idx] = ENABLE_;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tenure_cnt;
    logic             timeout_hit;
    logic             tmo_evt_q;

    assign timeout_hit = owner_req && pick_valid &&
                         (tenure_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rotate      = (!owner_req && pick_valid) || timeout_hit;
    assign tmo_evt     = tmo_evt_q;

    // Tenure only accumulates while the owner holds and someone else waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tenure_cnt <= '0;
            tmo_evt_q  <= 1'b0;
        end else if (rotate) begin
            tenure_cnt <= '0;
            tmo_evt_q  <= timeout_hit;
        end else begin
            tenure_cnt <= (owner_req && pick_valid) ? tenure_cnt + 1'b1 : '0;
            tmo_evt_q  <= 1'b0;
        end
    end
`else
    assign rotate  = !owner_req && pick_valid;
    assign tmo_evt = 1'b0;
`endif

    // Owner and grants move together so the grant never passes through all-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= BUS_OWNER_MASTER_0;
            grnt_n_q <= {DISABLE_, DISABLE_, DISABLE_, ENABLE_};
        end else if (rotate) begin
            owner_q  <= pick_idx;
            grnt_n_q <= grnt_n_next;
        end
    end

    assign owner    = owner_q;
    assign m0_grnt_ = grnt_n_q[0];
    assign m1_grnt_ = grnt_n_q[1];
    assign m2_grnt_ = grnt_n_q[2];
    assign m3_grnt_ = grnt_n_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, release, wrap/park, fairness,
// timeout (behaviour follows BUS_ARB_TIMEOUT_EN) and mid-tenure reset.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_n;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       tmo_evt;
    logic [3:0] grnt;
    logic       mon_en;

    int checks;
    int failures;

    assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    bus_arbiter #(
        .TIMEOUT_CYCLES (4),
        .TMO_W          (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .tmo_evt  (tmo_evt)
    );

    // Free-running bus clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exactly one grant low, and it must match owner, every cycle after reset.
    always @(negedge clk) begin
        if (mon_en) begin
            assert ($onehot(~grnt) && grnt[owner] == 1'b0)
            else $error("[TB] FAIL onehot_invariant grants=%b owner=%0d", grnt, owner);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        req_n = 4'b0000;
        reset = 1'b1;
        step(2);
        mon_en = 1'b1;
        checks++;
        if (owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_owner got=%0d exp=0", owner);
        end
        checks++;
        if (grnt !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL reset_grants got=%b exp=1110", grnt);
        end
        checks++;
        if (tmo_evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_tmo got=%b exp=0", tmo_evt);
        end
        reset = 1'b0;
    endtask

    task automatic test_release();
        req_n = 4'b1110;
        step(1);
        checks++;
        if (owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL release_hold got=%0d exp=0", owner);
        end
        req_n = 4'b0011;
        step(1);
        checks++;
        if (owner !== 2'd2 || grnt !== 4'b1011) begin
            failures++;
            $display("[TB] FAIL release_to_m2 got=%0d/%b exp=2/1011", owner, grnt);
        end
        req_n = 4'b0111;
        step(1);
        checks++;
        if (owner !== 2'd3 || grnt !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL release_to_m3 got=%0d/%b exp=3/0111", owner, grnt);
        end
    endtask

    task automatic test_wrap_park();
        req_n = 4'b1101;
        step(1);
        checks++;
        if (owner !== 2'd1 || grnt !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL wrap_to_m1 got=%0d/%b exp=1/1101", owner, grnt);
        end
        req_n = 4'b1111;
        step(3);
        checks++;
        if (owner !== 2'd1 || m1_grnt_ !== 1'b0) begin
            failures++;
            $display("[TB] FAIL park_m1 got=%0d/%b exp=1/0", owner, m1_grnt_);
        end
        req_n = 4'b1100;
        step(1);
        checks++;
        if (owner !== 2'd1 || grnt !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL rerequest_m1 got=%0d/%b exp=1/1101", owner, grnt);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset = 1'b1;
        req_n = 4'b0000;
        step(1);
        reset = 1'b0;
        for (int k = 1; k < 5; k++) begin
            req_n = 4'b0000;
            req_n[exp_seq[k-1]] = 1'b1;
            step(1);
            checks++;
            if (owner !== exp_seq[k]) begin
                failures++;
                $display("[TB] FAIL fair_step%0d got=%0d exp=%0d", k, owner, exp_seq[k]);
            end
        end
        req_n = 4'b1111;
        step(1);
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        req_n = 4'b1101;
        step(1);
        checks++;
        if (owner !== 2'd1) begin
            failures++;
            $display("[TB] FAIL tmo_setup got=%0d exp=1", owner);
        end
        req_n = 4'b1001;
`ifdef BUS_ARB_TIMEOUT_EN
        step(3);
        checks++;
        if (owner !== 2'd1 || tmo_evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_before got=%0d/%b exp=1/0", owner, tmo_evt);
        end
        step(1);
        checks++;
        if (owner !== 2'd2 || tmo_evt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tmo_rotate got=%0d/%b exp=2/1", owner, tmo_evt);
        end
        step(1);
        checks++;
        if (owner !== 2'd2 || tmo_evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_pulse_end got=%0d/%b exp=2/0", owner, tmo_evt);
        end
`else
        for (int c = 0; c < 100; c++) begin
            step(1);
            checks++;
            if (owner !== 2'd1 || tmo_evt !== 1'b0) begin
                failures++;
                $display("[TB] FAIL no_tmo_cycle%0d got=%0d/%b exp=1/0", c, owner, tmo_evt);
            end
        end
`endif
        req_n = 4'b1111;
        step(1);
    endtask

    task automatic test_midop_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        req_n = 4'b1011;
        step(1);
        checks++;
        if (owner !== 2'd2) begin
            failures++;
            $display("[TB] FAIL midop_setup got=%0d exp=2", owner);
        end
        step(1);
        reset = 1'b1;
        step(1);
        checks++;
        if (owner !== 2'd0 || grnt !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL midop_reset got=%0d/%b exp=0/1110", owner, grnt);
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (owner !== 2'd2 || grnt !== 4'b1011) begin
            failures++;
            $display("[TB] FAIL midop_recover got=%0d/%b exp=2/1011", owner, grnt);
        end
    endtask

    // Scenario sequence.
    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        req_n    = 4'b1111;
        test_reset();
        test_release();
        test_wrap_park();
        test_fairness();
        test_timeout();
        test_midop_reset();
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
